// File: rtl/calc_multi.sv
// calc_multi: keypad calculator with decimal operand entry, add/sub in one
// cycle, iterative shift-add multiply and restoring divide, result chaining,
// and a free-running digit/position scan for the display mux.
// Optional feature macro: CALC_DIV_EN (builds the restoring divider for key D;
// without it key D is treated as an invalid operator).
module calc_multi #(
  parameter int NDIG = 8,
  parameter int W    = 27,
  localparam int PW  = $clog2(NDIG)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [3:0]    cmd,
  input  logic          cmd_valid,
  output logic [1:0]    status,
  output logic [3:0]    data,
  output logic [PW-1:0] pos
);

  // 10**n for n in 0..NDIG, loop bound kept constant so it also works on a live pos
  function automatic logic [W-1:0] pow10(input int n);
    logic [W-1:0] p;
    p = W'(1);
    for (int i = 0; i < NDIG; i++) begin
      if (i < n) p = p * W'(10);
    end
    return p;
  endfunction

  localparam logic [W-1:0] MAXVAL = pow10(NDIG) - W'(1);
  localparam logic [W-1:0] NEGMAX = pow10(NDIG - 1) - W'(1);
  localparam int           CW     = $clog2(W + 1);

  typedef enum logic [1:0] {
    ENTER_A = 2'd0,
    ENTER_B = 2'd1,
    CALC    = 2'd2,
    ERROR   = 2'd3
  } CalcState;

  CalcState state, nextState;

  logic [W-1:0]   curVal, opA, opB;
  logic [3:0]     opCode;
  logic           negFlag, freshResult;
  logic [CW-1:0]  cycleCnt;
  logic [2*W-1:0] prod, mcand;
  logic [W-1:0]   mplier;

  logic           cmdAccept, isDigit, isOp, opAllowed, digitOk;
  logic           doDigit, doBack, doLatchA, doLatchB;
  logic [W-1:0]   digitBase;
  logic [W+3:0]   appended;
  logic [W:0]     sumWide;
  logic [2*W-1:0] resWide;
  logic           resNeg, divZero, resErr, iterDone;
  logic [3:0]     shownDigit;
  logic           minusSlot;

`ifdef CALC_DIV_EN
  logic [W-1:0]   remReg, quotReg;
  logic [W:0]     remShift;
  logic           remFits;
`endif

  // State register; reset returns to operand A entry from anywhere, even mid-iteration
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ENTER_A;
    else       state <= nextState;
  end

  // Key decode: a key counts only while ready, and a digit only if the entry stays in range
  always_comb begin
    cmdAccept = cmd_valid && ((state == ENTER_A) || (state == ENTER_B));
    isDigit   = (cmd <= 4'd9);
    isOp      = (cmd >= 4'hA) && (cmd <= 4'hD);
    digitBase = freshResult ? '0 : curVal;
    appended  = ({4'b0000, digitBase} * (W+4)'(10)) + {{W{1'b0}}, cmd};
    digitOk   = (appended <= {4'b0000, MAXVAL});
`ifdef CALC_DIV_EN
    opAllowed = !negFlag;
`else
    opAllowed = !negFlag && (cmd != 4'hD);
`endif
    doDigit   = cmdAccept && isDigit && digitOk;
    doBack    = cmdAccept && (cmd == 4'hF);
    doLatchA  = cmdAccept && (state == ENTER_A) && isOp && opAllowed;
    doLatchB  = cmdAccept && (state == ENTER_B) && (cmd == 4'hE);
  end

  // Result selection and range checks evaluated in the final CALC cycle
  always_comb begin
    sumWide = {1'b0, opA} + {1'b0, opB};
    resWide = '0;
    resNeg  = 1'b0;
    divZero = 1'b0;
    case (opCode)
      4'hA: resWide = {{(W-1){1'b0}}, sumWide};
      4'hB: begin
        if (opA >= opB) begin
          resWide = {{W{1'b0}}, opA - opB};
        end else begin
          resWide = {{W{1'b0}}, opB - opA};
          resNeg  = 1'b1;
        end
      end
      4'hC: resWide = prod;
`ifdef CALC_DIV_EN
      4'hD: begin
        resWide = {{W{1'b0}}, quotReg};
        divZero = (opB == '0);
      end
`endif
      default: resWide = '0;
    endcase
    resErr   = divZero
            || (resWide > {{W{1'b0}}, MAXVAL})
            || (resNeg && (resWide > {{W{1'b0}}, NEGMAX}));
    iterDone = (opCode == 4'hA) || (opCode == 4'hB) || (cycleCnt == CW'(W));
  end

`ifdef CALC_DIV_EN
  // One restoring-divide trial: shift in the next dividend bit and try subtracting B
  always_comb begin
    remShift = {remReg, quotReg[W-1]};
    remFits  = (remShift >= {1'b0, opB});
  end
`endif

  // Display digit for the slot currently being scanned
  always_comb begin
    shownDigit = 4'((curVal / pow10(int'(pos))) % W'(10));
    minusSlot  = negFlag && (pos == PW'(NDIG - 1));
  end

  // Next-state and output decode; error overrides every slot, busy blanks to zero
  always_comb begin
    nextState = state;
    status    = 2'b10;
    data      = 4'h0;
    case (state)
      ENTER_A: begin
        if (cmdAccept && isOp) nextState = opAllowed ? ENTER_B : ERROR;
        data = minusSlot ? 4'hA : shownDigit;
      end
      ENTER_B: begin
        if (cmdAccept && isOp)               nextState = ERROR;
        else if (cmdAccept && cmd == 4'hE)   nextState = CALC;
        data = minusSlot ? 4'hA : shownDigit;
      end
      CALC: begin
        status = 2'b01;
        if (iterDone) nextState = resErr ? ERROR : ENTER_A;
      end
      ERROR: begin
        status = 2'b00;
        data   = 4'hE;
      end
      default: nextState = ERROR;
    endcase
  end

  // Operand entry, operator latching, iterative mul/div steps and result write-back
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      curVal      <= '0;
      opA         <= '0;
      opB         <= '0;
      opCode      <= 4'hA;
      negFlag     <= 1'b0;
      freshResult <= 1'b0;
      cycleCnt    <= '0;
      prod        <= '0;
      mcand       <= '0;
      mplier      <= '0;
`ifdef CALC_DIV_EN
      remReg      <= '0;
      quotReg     <= '0;
`endif
    end else if (doDigit) begin
      curVal <= appended[W-1:0];
      if (freshResult) begin
        freshResult <= 1'b0;
        negFlag     <= 1'b0;
      end
    end else if (doBack) begin
      curVal <= curVal / W'(10);
    end else if (doLatchA) begin
      opA         <= curVal;
      opCode      <= cmd;
      curVal      <= '0;
      freshResult <= 1'b0;
    end else if (doLatchB) begin
      opB      <= curVal;
      cycleCnt <= '0;
      prod     <= '0;
      mcand    <= {{W{1'b0}}, opA};
      mplier   <= curVal;
`ifdef CALC_DIV_EN
      remReg   <= '0;
      quotReg  <= opA;
`endif
    end else if (state == CALC) begin
      if (!iterDone) begin
        cycleCnt <= cycleCnt + CW'(1);
        if (mplier[0]) prod <= prod + mcand;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
`ifdef CALC_DIV_EN
        remReg  <= remFits ? remShift[W-1:0] - opB : remShift[W-1:0];
        quotReg <= {quotReg[W-2:0], remFits};
`endif
      end else if (!resErr) begin
        curVal      <= resWide[W-1:0];
        opA         <= resWide[W-1:0];
        negFlag     <= resNeg;
        freshResult <= 1'b1;
      end
    end
  end

  // Display scan position runs every clock in every state
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                       pos <= '0;
    else if (pos == PW'(NDIG - 1))   pos <= '0;
    else                             pos <= pos + PW'(1);
  end

endmodule

// File: tb/tb_calc_multi.sv
// tb_calc_multi: directed key sequences for calc_multi (NDIG=8, W=27) with
// hand-computed display images, busy lengths and error/reset behaviour.
`timescale 1ns/1ps
module tb_calc_multi;

  localparam int NDIG = 8;
  localparam int W    = 27;
  localparam int PW   = 3;

  logic          clock = 1'b0;
  logic          reset;
  logic [3:0]    cmd;
  logic          cmd_valid;
  logic [1:0]    status;
  logic [3:0]    data;
  logic [PW-1:0] pos;

  int checks = 0;
  int errors = 0;
  int busyCycles;
  logic [31:0] shown;

  calc_multi #(.NDIG(NDIG), .W(W)) dut (
    .clock     (clock),
    .reset     (reset),
    .cmd       (cmd),
    .cmd_valid (cmd_valid),
    .status    (status),
    .data      (data),
    .pos       (pos)
  );

  // 10 ns clock
  always #5 clock = ~clock;

  // Guard against any unexpected stall
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Present one key for exactly one rising edge
  task automatic applyStimulus(input logic [3:0] key);
    @(negedge clock);
    cmd       = key;
    cmd_valid = 1'b1;
    @(negedge clock);
    cmd_valid = 1'b0;
    cmd       = 4'h0;
  endtask

  // Collect one full scan of the display, one nibble per slot, slot 0 lowest
  task automatic readDisplay(output logic [31:0] img);
    img = 32'hFFFF_FFFF;
    for (int i = 0; i < NDIG; i++) begin
      @(negedge clock);
      img[int'(pos)*4 +: 4] = data;
    end
  endtask

  // Count busy samples (including the current one) until status leaves 01
  task automatic waitNotBusy(input int budget, output int cycles);
    cycles = 0;
    if (status == 2'b01) cycles = 1;
    while (status == 2'b01 && cycles < budget) begin
      @(negedge clock);
      if (status == 2'b01) cycles++;
    end
  endtask

  task automatic pulseReset();
    @(negedge clock);
    reset = 1'b1;
    #1;
    checkOutput("rst_status", status, 2'b10);
    checkOutput("rst_pos", pos, 0);
    checkOutput("rst_data", data, 4'h0);
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    cmd       = 4'h0;
    cmd_valid = 1'b0;
    repeat (2) @(negedge clock);
    checkOutput("init_status", status, 2'b10);
    checkOutput("init_pos", pos, 0);
    checkOutput("init_data", data, 4'h0);
    reset = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      @(negedge clock);
      checkOutput("pos_scan", pos, i % 8);
    end

    // 123 + 45 = 168, busy for a single cycle
    applyStimulus(4'h1); applyStimulus(4'h2); applyStimulus(4'h3);
    applyStimulus(4'hA);
    applyStimulus(4'h4); applyStimulus(4'h5);
    applyStimulus(4'hE);
    checkOutput("add_busy", status, 2'b01);
    waitNotBusy(60, busyCycles);
    checkOutput("add_busy_len", busyCycles, 1);
    checkOutput("add_ready", status, 2'b10);
    readDisplay(shown);
    checkOutput("add_display", shown, 32'h0000_0168);

    // 5 - 9 = -4, then an operator on a negative value is an error
    applyStimulus(4'h5); applyStimulus(4'hB); applyStimulus(4'h9);
    applyStimulus(4'hE);
    waitNotBusy(60, busyCycles);
    checkOutput("sub_ready", status, 2'b10);
    readDisplay(shown);
    checkOutput("sub_display", shown, 32'hA000_0004);
    applyStimulus(4'hA);
    checkOutput("neg_op_status", status, 2'b00);
    readDisplay(shown);
    checkOutput("neg_op_display", shown, 32'hEEEE_EEEE);
    pulseReset();

    // 12 * 34 = 408 over 28 busy cycles, then chained + 2 = 410
    applyStimulus(4'h1); applyStimulus(4'h2); applyStimulus(4'hC);
    applyStimulus(4'h3); applyStimulus(4'h4); applyStimulus(4'hE);
    waitNotBusy(60, busyCycles);
    checkOutput("mul_busy_len", busyCycles, 28);
    checkOutput("mul_ready", status, 2'b10);
    readDisplay(shown);
    checkOutput("mul_display", shown, 32'h0000_0408);
    applyStimulus(4'hA); applyStimulus(4'h2); applyStimulus(4'hE);
    waitNotBusy(60, busyCycles);
    checkOutput("chain_busy_len", busyCycles, 1);
    readDisplay(shown);
    checkOutput("chain_display", shown, 32'h0000_0410);

    // Nine 9s: the ninth is dropped; 99999999 * 2 overflows into error
    for (int i = 0; i < 9; i++) applyStimulus(4'h9);
    readDisplay(shown);
    checkOutput("max_entry", shown, 32'h9999_9999);
    applyStimulus(4'hC); applyStimulus(4'h2); applyStimulus(4'hE);
    waitNotBusy(60, busyCycles);
    checkOutput("ovf_status", status, 2'b00);
    repeat (20) @(negedge clock);
    checkOutput("ovf_hold", status, 2'b00);
    readDisplay(shown);
    checkOutput("ovf_display", shown, 32'hEEEE_EEEE);
    pulseReset();

`ifdef CALC_DIV_EN
    // 100 / 7 = 14, then division by zero
    applyStimulus(4'h1); applyStimulus(4'h0); applyStimulus(4'h0);
    applyStimulus(4'hD); applyStimulus(4'h7); applyStimulus(4'hE);
    waitNotBusy(60, busyCycles);
    checkOutput("div_busy_len", busyCycles, 28);
    readDisplay(shown);
    checkOutput("div_display", shown, 32'h0000_0014);
    applyStimulus(4'h5); applyStimulus(4'hD); applyStimulus(4'h0);
    applyStimulus(4'hE);
    waitNotBusy(60, busyCycles);
    checkOutput("div0_status", status, 2'b00);
`else
    // Without the divider, D is an invalid operator
    applyStimulus(4'h5); applyStimulus(4'hD);
    checkOutput("nodiv_status", status, 2'b00);
`endif
    pulseReset();

    // Backspace, keys ignored while busy, reset in the middle of a multiply
    applyStimulus(4'h1); applyStimulus(4'h2); applyStimulus(4'hF);
    readDisplay(shown);
    checkOutput("bksp_display", shown, 32'h0000_0001);
    applyStimulus(4'hC); applyStimulus(4'h3); applyStimulus(4'hE);
    applyStimulus(4'hA); applyStimulus(4'h3); applyStimulus(4'hC);
    checkOutput("busy_ignore_status", status, 2'b01);
    waitNotBusy(60, busyCycles);
    checkOutput("busy_ignore_ready", status, 2'b10);
    readDisplay(shown);
    checkOutput("busy_ignore_display", shown, 32'h0000_0003);
    applyStimulus(4'hC); applyStimulus(4'h5); applyStimulus(4'hE);
    repeat (5) @(negedge clock);
    checkOutput("midmul_busy", status, 2'b01);
    pulseReset();
    readDisplay(shown);
    checkOutput("post_reset_display", shown, 32'h0000_0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
